// File: rtl/top_k_merger.sv
// Running best-4 accumulator: merges NUM_BATCHES sorted 4-entry batches per query
// into one global ascending best-4 list keyed on {dist, idx}.
module top_k_merger #(
  parameter int DIST_WIDTH  = 25,
  parameter int IDX_WIDTH   = 15,
  parameter int K           = 4,
  parameter int NUM_BATCHES = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  input  logic [DIST_WIDTH-1:0]              data_in_0,
  input  logic [DIST_WIDTH-1:0]              data_in_1,
  input  logic [DIST_WIDTH-1:0]              data_in_2,
  input  logic [DIST_WIDTH-1:0]              data_in_3,
  input  logic [IDX_WIDTH-1:0]               idx_in_0,
  input  logic [IDX_WIDTH-1:0]               idx_in_1,
  input  logic [IDX_WIDTH-1:0]               idx_in_2,
  input  logic [IDX_WIDTH-1:0]               idx_in_3,
  output logic                               valid_out,
  output logic [DIST_WIDTH-1:0]              data_out_0,
  output logic [DIST_WIDTH-1:0]              data_out_1,
  output logic [DIST_WIDTH-1:0]              data_out_2,
  output logic [DIST_WIDTH-1:0]              data_out_3,
  output logic [IDX_WIDTH-1:0]               idx_out_0,
  output logic [IDX_WIDTH-1:0]               idx_out_1,
  output logic [IDX_WIDTH-1:0]               idx_out_2,
  output logic [IDX_WIDTH-1:0]               idx_out_3,
  output logic [$clog2(NUM_BATCHES+1)-1:0]   batch_cnt
);

  localparam int KW = DIST_WIDTH + IDX_WIDTH;
  localparam int CW = $clog2(NUM_BATCHES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BATCHES - 1);

  logic [KW-1:0] best [K];
  logic [KW-1:0] res  [K];
  logic [KW-1:0] s    [K];
  logic [KW-1:0] b    [K];
  logic [KW-1:0] m    [K];
  logic [KW-1:0] t    [K];
  logic [KW-1:0] r    [K];
  logic [CW-1:0] cnt;

  function automatic logic [KW-1:0] kmin(input logic [KW-1:0] x, input logic [KW-1:0] y);
    return (x < y) ? x : y;
  endfunction

  function automatic logic [KW-1:0] kmax(input logic [KW-1:0] x, input logic [KW-1:0] y);
    return (x < y) ? y : x;
  endfunction

  // Reversing the batch against the running list makes the pairwise minima
  // bitonic, so a 2-stage half-cleaner finishes the sort.
  always_comb begin
    b[0] = {data_in_0, idx_in_0};
    b[1] = {data_in_1, idx_in_1};
    b[2] = {data_in_2, idx_in_2};
    b[3] = {data_in_3, idx_in_3};

    s[0] = (cnt == '0) ? '1 : best[0];
    s[1] = (cnt == '0) ? '1 : best[1];
    s[2] = (cnt == '0) ? '1 : best[2];
    s[3] = (cnt == '0) ? '1 : best[3];

    m[0] = kmin(s[0], b[3]);
    m[1] = kmin(s[1], b[2]);
    m[2] = kmin(s[2], b[1]);
    m[3] = kmin(s[3], b[0]);

    t[0] = kmin(m[0], m[2]);
    t[2] = kmax(m[0], m[2]);
    t[1] = kmin(m[1], m[3]);
    t[3] = kmax(m[1], m[3]);

    r[0] = kmin(t[0], t[1]);
    r[1] = kmax(t[0], t[1]);
    r[2] = kmin(t[2], t[3]);
    r[3] = kmax(t[2], t[3]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best      <= '{default: '1};
      res       <= '{default: '0};
      cnt       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        best <= r;
        if (cnt == LAST) begin
          cnt       <= '0;
          valid_out <= 1'b1;
          res       <= r;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign data_out_0 = res[0][KW-1:IDX_WIDTH];
  assign data_out_1 = res[1][KW-1:IDX_WIDTH];
  assign data_out_2 = res[2][KW-1:IDX_WIDTH];
  assign data_out_3 = res[3][KW-1:IDX_WIDTH];
  assign idx_out_0  = res[0][IDX_WIDTH-1:0];
  assign idx_out_1  = res[1][IDX_WIDTH-1:0];
  assign idx_out_2  = res[2][IDX_WIDTH-1:0];
  assign idx_out_3  = res[3][IDX_WIDTH-1:0];
  assign batch_cnt  = cnt;

endmodule

// File: tb/tb_top_k_merger.sv
// Bench for top_k_merger: three instances (NUM_BATCHES 1, 2, 4) share one input
// stream; directed scenarios plus random traffic against a gather-and-sort model.
module tb_top_k_merger;

  localparam int DW = 25;
  localparam int IW = 15;
  localparam int KW = DW + IW;
  localparam int DMAX = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_in = 1'b0;
  logic [DW-1:0] data_in_0 = '0, data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
  logic [IW-1:0] idx_in_0 = '0, idx_in_1 = '0, idx_in_2 = '0, idx_in_3 = '0;

  logic          ov [3];
  logic [DW-1:0] od [3][4];
  logic [IW-1:0] oi [3][4];
  logic [0:0]    bc1;
  logic [1:0]    bc2;
  logic [2:0]    bc4;

  logic [4*KW-1:0] obs_res [3];
  int              obs_cnt [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  top_k_merger #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(4), .NUM_BATCHES(1)) u1 (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .idx_in_0(idx_in_0), .idx_in_1(idx_in_1), .idx_in_2(idx_in_2), .idx_in_3(idx_in_3),
    .valid_out(ov[0]),
    .data_out_0(od[0][0]), .data_out_1(od[0][1]), .data_out_2(od[0][2]), .data_out_3(od[0][3]),
    .idx_out_0(oi[0][0]), .idx_out_1(oi[0][1]), .idx_out_2(oi[0][2]), .idx_out_3(oi[0][3]),
    .batch_cnt(bc1));

  top_k_merger #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(4), .NUM_BATCHES(2)) u2 (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .idx_in_0(idx_in_0), .idx_in_1(idx_in_1), .idx_in_2(idx_in_2), .idx_in_3(idx_in_3),
    .valid_out(ov[1]),
    .data_out_0(od[1][0]), .data_out_1(od[1][1]), .data_out_2(od[1][2]), .data_out_3(od[1][3]),
    .idx_out_0(oi[1][0]), .idx_out_1(oi[1][1]), .idx_out_2(oi[1][2]), .idx_out_3(oi[1][3]),
    .batch_cnt(bc2));

  top_k_merger #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(4), .NUM_BATCHES(4)) u4 (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .idx_in_0(idx_in_0), .idx_in_1(idx_in_1), .idx_in_2(idx_in_2), .idx_in_3(idx_in_3),
    .valid_out(ov[2]),
    .data_out_0(od[2][0]), .data_out_1(od[2][1]), .data_out_2(od[2][2]), .data_out_3(od[2][3]),
    .idx_out_0(oi[2][0]), .idx_out_1(oi[2][1]), .idx_out_2(oi[2][2]), .idx_out_3(oi[2][3]),
    .batch_cnt(bc4));

  always_comb begin
    for (int d = 0; d < 3; d++)
      obs_res[d] = {od[d][0], oi[d][0], od[d][1], oi[d][1], od[d][2], oi[d][2], od[d][3], oi[d][3]};
    obs_cnt[0] = int'(bc1);
    obs_cnt[1] = int'(bc2);
    obs_cnt[2] = int'(bc4);
  end

  // Reference model: gather every key of the open query, sort all of them on
  // completion and keep the first four.
  int              nbs [3] = '{1, 2, 4};
  logic [KW-1:0]   mk [3][256];
  int              mn [3] = '{0, 0, 0};
  int              mdl_cnt [3] = '{0, 0, 0};
  logic            mdl_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [4*KW-1:0] mdl_res [3] = '{'0, '0, '0};

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      mdl_v[d] = 1'b0;
      if (rst) begin
        mn[d] = 0;
        mdl_cnt[d] = 0;
        mdl_res[d] = '0;
      end else if (valid_in) begin
        mk[d][mn[d]]     = {data_in_0, idx_in_0};
        mk[d][mn[d] + 1] = {data_in_1, idx_in_1};
        mk[d][mn[d] + 2] = {data_in_2, idx_in_2};
        mk[d][mn[d] + 3] = {data_in_3, idx_in_3};
        mn[d] += 4;
        mdl_cnt[d]++;
        if (mdl_cnt[d] == nbs[d]) begin
          for (int i = 0; i < mn[d]; i++)
            for (int j = 0; j < mn[d] - 1 - i; j++)
              if (mk[d][j] > mk[d][j + 1]) begin
                logic [KW-1:0] tmp;
                tmp = mk[d][j];
                mk[d][j] = mk[d][j + 1];
                mk[d][j + 1] = tmp;
              end
          mdl_res[d] = {mk[d][0], mk[d][1], mk[d][2], mk[d][3]};
          mdl_v[d] = 1'b1;
          mn[d] = 0;
          mdl_cnt[d] = 0;
        end
      end
    end
  end

  function automatic logic [4*KW-1:0] pk(input int d0, input int d1, input int d2, input int d3,
                                         input int i0, input int i1, input int i2, input int i3);
    return {DW'(d0), IW'(i0), DW'(d1), IW'(i1), DW'(d2), IW'(i2), DW'(d3), IW'(i3)};
  endfunction

  task automatic cycle(input bit r, input bit v, input int d0, input int d1, input int d2, input int d3,
                       input int i0, input int i1, input int i2, input int i3);
    @(negedge clk);
    rst = r; valid_in = v;
    data_in_0 = DW'(d0); data_in_1 = DW'(d1); data_in_2 = DW'(d2); data_in_3 = DW'(d3);
    idx_in_0 = IW'(i0); idx_in_1 = IW'(i1); idx_in_2 = IW'(i2); idx_in_3 = IW'(i3);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    // Load some state first so reset has something to clear.
    cycle(0, 1, 3, 4, 5, 6, 1, 2, 3, 4);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || obs_res[d] !== '0 || obs_cnt[d] !== 0) begin
        failures++;
        $display("FAIL reset d=%0d: valid=%b res=%h cnt=%0d, want valid=0 res=0 cnt=0", d, ov[d], obs_res[d], obs_cnt[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [4*KW-1:0] want;
    do_reset();
    want = pk(0, 1, 2, 2, 0, 0, 1, 2);
    cycle(0, 1, 0, 3, 20, 83, 0, 1, 2, 3);
    checks++;
    if (ov[1] !== 1'b0 || obs_cnt[1] !== 1) begin
      failures++;
      $display("FAIL basic_first: valid=%b cnt=%0d, want valid=0 cnt=1", ov[1], obs_cnt[1]);
    end
    cycle(0, 1, 1, 2, 2, 11, 0, 1, 2, 3);
    checks++;
    if (ov[1] !== 1'b1 || obs_res[1] !== want || obs_cnt[1] !== 0) begin
      failures++;
      $display("FAIL basic_result: valid=%b res=%h cnt=%0d, want valid=1 res=%h cnt=0", ov[1], obs_res[1], obs_cnt[1], want);
    end
    idle(1);
    checks++;
    if (ov[1] !== 1'b0 || obs_res[1] !== want) begin
      failures++;
      $display("FAIL basic_hold: valid=%b res=%h, want valid=0 res=%h", ov[1], obs_res[1], want);
    end
  endtask

  task automatic test_gaps();
    int gap [4] = '{0, 3, 1, 0};
    int dd [4][4] = '{'{10, 11, 12, 13}, '{1, 50, 60, 70}, '{2, 3, 90, 91}, '{0, 100, 101, 102}};
    int want_cnt [4] = '{1, 2, 3, 0};
    logic [4*KW-1:0] want;
    do_reset();
    want = pk(0, 1, 2, 3, 12, 4, 8, 9);
    for (int bt = 0; bt < 4; bt++) begin
      cycle(0, 1, dd[bt][0], dd[bt][1], dd[bt][2], dd[bt][3], 4*bt, 4*bt + 1, 4*bt + 2, 4*bt + 3);
      checks++;
      if (obs_cnt[2] !== want_cnt[bt] || ov[2] !== (bt == 3)) begin
        failures++;
        $display("FAIL gaps_cnt b=%0d: cnt=%0d valid=%b, want cnt=%0d valid=%0d", bt, obs_cnt[2], ov[2], want_cnt[bt], bt == 3);
      end
      for (int g = 0; g < gap[bt]; g++) begin
        idle(1);
        checks++;
        if (ov[2] !== 1'b0 || obs_cnt[2] !== want_cnt[bt]) begin
          failures++;
          $display("FAIL gaps_idle b=%0d: valid=%b cnt=%0d, want valid=0 cnt=%0d", bt, ov[2], obs_cnt[2], want_cnt[bt]);
        end
      end
    end
    checks++;
    if (obs_res[2] !== want) begin
      failures++;
      $display("FAIL gaps_result: res=%h, want %h", obs_res[2], want);
    end
  endtask

  task automatic test_back_to_back();
    logic [4*KW-1:0] want1, want2;
    logic vseen [4];
    do_reset();
    want1 = pk(0, 1, 2, 2, 0, 0, 1, 2);
    want2 = pk(1000, 1001, 1002, 1003, 0, 1, 2, 3);
    cycle(0, 1, 0, 3, 20, 83, 0, 1, 2, 3);        vseen[0] = ov[1];
    cycle(0, 1, 1, 2, 2, 11, 0, 1, 2, 3);         vseen[1] = ov[1];
    checks++;
    if (obs_res[1] !== want1) begin
      failures++;
      $display("FAIL b2b_first: res=%h, want %h", obs_res[1], want1);
    end
    cycle(0, 1, 1000, 1001, 1002, 1003, 0, 1, 2, 3); vseen[2] = ov[1];
    cycle(0, 1, 1004, 1005, 1006, 1007, 0, 1, 2, 3); vseen[3] = ov[1];
    checks++;
    if (obs_res[1] !== want2) begin
      failures++;
      $display("FAIL b2b_second: res=%h, want %h", obs_res[1], want2);
    end
    checks++;
    if ({vseen[0], vseen[1], vseen[2], vseen[3]} !== 4'b0101) begin
      failures++;
      $display("FAIL b2b_pulses: valid seq=%b%b%b%b, want 0101", vseen[0], vseen[1], vseen[2], vseen[3]);
    end
  endtask

  task automatic test_ties();
    logic [4*KW-1:0] want;
    do_reset();
    want = pk(DMAX, DMAX, DMAX, DMAX, 0, 1, 2, 3);
    cycle(0, 1, DMAX, DMAX, DMAX, DMAX, 4, 5, 6, 7);
    cycle(0, 1, DMAX, DMAX, DMAX, DMAX, 0, 1, 2, 3);
    checks++;
    if (ov[1] !== 1'b1 || obs_res[1] !== want) begin
      failures++;
      $display("FAIL ties: valid=%b res=%h, want valid=1 res=%h", ov[1], obs_res[1], want);
    end
  endtask

  task automatic test_reset_mid();
    logic [4*KW-1:0] want;
    do_reset();
    want = pk(5, 5, 5, 5, 0, 4, 8, 12);
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 2, 3);
    cycle(0, 1, 0, 0, 0, 0, 4, 5, 6, 7);
    cycle(1, 1, 0, 0, 0, 0, 8, 9, 10, 11);
    checks++;
    if (ov[2] !== 1'b0 || obs_res[2] !== '0 || obs_cnt[2] !== 0) begin
      failures++;
      $display("FAIL rstmid_clear: valid=%b res=%h cnt=%0d, want valid=0 res=0 cnt=0", ov[2], obs_res[2], obs_cnt[2]);
    end
    for (int bt = 0; bt < 4; bt++) begin
      cycle(0, 1, 5, 6, 7, 8, 4*bt, 4*bt + 1, 4*bt + 2, 4*bt + 3);
      checks++;
      if (ov[2] !== (bt == 3)) begin
        failures++;
        $display("FAIL rstmid_valid b=%0d: valid=%b, want %0d", bt, ov[2], bt == 3);
      end
    end
    checks++;
    if (obs_res[2] !== want) begin
      failures++;
      $display("FAIL rstmid_result: res=%h, want %h", obs_res[2], want);
    end
  endtask

  task automatic test_random();
    logic [KW-1:0] k [4];
    logic [KW-1:0] tmp;
    bit r, v;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 4; j++) begin
        k[j] = {DW'($urandom_range(0, 15)), IW'($urandom_range(0, 7))};
        if ($urandom_range(0, 15) == 0) k[j][KW-1:IW] = '1;
      end
      for (int a = 0; a < 4; a++)
        for (int j = 0; j < 3 - a; j++)
          if (k[j] > k[j + 1]) begin
            tmp = k[j]; k[j] = k[j + 1]; k[j + 1] = tmp;
          end
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      cycle(r, v, int'(k[0][KW-1:IW]), int'(k[1][KW-1:IW]), int'(k[2][KW-1:IW]), int'(k[3][KW-1:IW]),
            int'(k[0][IW-1:0]), int'(k[1][IW-1:0]), int'(k[2][IW-1:0]), int'(k[3][IW-1:0]));
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (ov[d] !== mdl_v[d] || obs_res[d] !== mdl_res[d] || obs_cnt[d] !== mdl_cnt[d]) begin
          failures++;
          $display("FAIL random n=%0d d=%0d: valid=%b res=%h cnt=%0d, want valid=%b res=%h cnt=%0d",
                   n, d, ov[d], obs_res[d], obs_cnt[d], mdl_v[d], mdl_res[d], mdl_cnt[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_ties();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top_k_merger.md
# top_k_merger

Running top-K accumulator that sits directly downstream of the bitonic sorter. It consumes the sorter's per-cycle sorted best-4 (distance, index) lists. It merges NUM_BATCHES consecutive lists belonging to one query into a single global best-K list. When the query is complete it emits that list with a one-cycle valid pulse toward the result writer.

## Interface
- DIST_WIDTH, 25, distance width (matches sorter)
- IDX_WIDTH, 15, candidate index width (leaf address + patch index, LEAF_ADDRW+9)
- K, 4, list length; fixed at 4 for this revision
- NUM_BATCHES, 4, sorter outputs merged per query; range 1..64

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  sorter output valid; one batch per asserted cycle
- data_in_0..data_in_3  in  DIST_WIDTH each  batch distances, ascending
- idx_in_0..idx_in_3  in  IDX_WIDTH each  batch indices, paired with data_in_n
- valid_out  out  1  one-cycle pulse, final result for a query
- data_out_0..data_out_3  out  DIST_WIDTH each  global best-4 distances, ascending
- idx_out_0..idx_out_3  out  IDX_WIDTH each  paired indices
- batch_cnt  out  clog2(NUM_BATCHES+1)  batches accepted for the current query (debug/status)

## Operation
- **Ordering key**
  - Every comparison uses key = {dist, idx}, unsigned, dist in the MSBs.
  - Equal distances resolve to the lower idx, so the result is fully deterministic.
  - Input batches are sorted ascending by this key. Behaviour on unsorted input is undefined.
- **State**
  - best[0..3] (dist, idx) registers and batch counter cnt.
  - Reset: best = all-ones keys; cnt = 0.
- **Merge (combinational, single cycle)**
  - Inputs: s = best or, when cnt==0, all-ones keys. b = incoming batch.
  - Step 1: m[i] = min(s[i], b[3-i]) for i = 0..3. The result is bitonic.
  - Step 2: compare-exchange (0,2) and (1,3).
  - Step 3: compare-exchange (0,1) and (2,3).
  - Result: the four smallest keys of the 8, ascending.
- **On valid_in**
  - If cnt < NUM_BATCHES-1: best <= merge, cnt <= cnt+1.
  - If cnt == NUM_BATCHES-1: data_out/idx_out <= merge, valid_out <= 1, cnt <= 0. best <= merge (don't-care, since cnt==0 ignores it).
- **Without valid_in:** state holds and cnt does not advance. Gaps of any length between batches are allowed.
- **Queries:** a new query starts automatically on the batch after the final one. There is no start strobe.
- **NUM_BATCHES==1:** every valid batch produces a result with valid_out the next cycle.

## Timing
- Reset values:
  - valid_out = 0
  - data_out_n = 0, idx_out_n = 0
  - batch_cnt = 0
  - best = all-ones
- Latency: valid_out rises on the clock edge after the cycle in which the final batch is presented. It lasts exactly one cycle unless the next query's final batch also completes on the next cycle (only possible when NUM_BATCHES==1).
- data_out/idx_out update only when valid_out is set. They hold their value until the next result.
- Throughput: one batch per cycle sustained; no backpressure. The downstream stage must accept every valid_out pulse.
- rst has priority over valid_in in the same cycle. The batch presented in that cycle is dropped.
- rst mid-query discards the partial result; the next accepted batch is batch 0 of a new query.
- batch_cnt reflects cnt after the edge, i.e. the number of batches accepted so far in the open query.

## Test plan
- **Basic merge, NUM_BATCHES=2:**
  - Stimulus: batch A dist {0,3,20,83}, idx {0,1,2,3}; next cycle batch B dist {1,2,2,11}, idx {0,1,2,3}.
  - Response: one cycle after B, valid_out=1 with dist {0,1,2,2} and idx {0,0,1,2}.
  - valid_out is 0 the following cycle and outputs hold.
- **Gaps, NUM_BATCHES=4:**
  - Stimulus: batches {10,11,12,13}, {1,50,60,70}, {2,3,90,91}, {0,100,101,102} with idx = 4·batch+lane. Insert 0, 3, 1 idle cycles between them.
  - Response: single valid_out, one cycle after the 4th batch, dist {0,1,2,3}, idx {12,4,8,9}.
  - batch_cnt steps 1, 2, 3, 0.
- **Back-to-back queries, NUM_BATCHES=2:**
  - Stimulus: query 1 as in the first scenario, then immediately batches {1000,1001,1002,1003} and {1004,1005,1006,1007} with idx {0..3}.
  - Response: second result dist {1000,1001,1002,1003}. Nothing from query 1 leaks into it.
  - valid_out pulses twice, 2 cycles apart.
- **Tie and saturation, NUM_BATCHES=2:**
  - Stimulus: batch A all dist 2^25-1, idx {4,5,6,7}; batch B all dist 2^25-1, idx {0,1,2,3}.
  - Response: dist all 2^25-1, idx {0,1,2,3}.
- **Reset mid-query, NUM_BATCHES=4:**
  - Stimulus: two batches of dist {0,0,0,0}, then rst for 1 cycle concurrent with a valid batch, then four batches of {5,6,7,8} with idx = 4·batch+lane.
  - Response: valid_out is 0 and outputs are 0 after reset.
  - The only result arrives after the fourth fresh batch: dist {5,5,5,5}, idx {0,4,8,12}.
